imem_boot_loader: RTL

- Upstream feeder for the core's instruction memory.
- Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them to sequential instruction-memory word addresses.
- Holds the core stopped (core_run=0) until a complete program has loaded, then releases it.
- Sits between the external program source (UART/debug bridge) and the instruction-memory write port.

---
 rtl/imem_boot_loader_if.sv | 22 ++
 rtl/imem_boot_loader.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader uses the slave modport; the program source/memory side uses master.
interface imem_boot_loader_if #(
    parameter int unsigned ADDR_W = 6
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory, then releases the core.
// Optional trailing XOR checksum byte enabled by IMEM_BOOT_LOADER_CHECKSUM_EN.
module imem_boot_loader #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    imem_boot_loader_if.slave bus,
    output logic              core_run,
    output logic              busy,
    output logic              err
);
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERROR
    } state_t;

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    localparam state_t LAST_NEXT = S_CSUM;
`else
    localparam state_t LAST_NEXT = S_DONE;
`endif

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, widx_q, len_next;
    logic [1:0]        bcnt_q;
    logic [WORD_W-1:0] word_q, word_next;
    logic              accept, reload, len_last, word_last;
    logic              in_ready_d, imem_we_d, core_run_d, busy_d, err_d;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q;
`endif

    assign accept    = bus.in_valid & bus.in_ready;
    assign reload    = start & ((state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_ERROR));
    assign len_next  = {bus.in_data, len_q[BYTE_W-1:0]};
    assign word_next = {bus.in_data, word_q[WORD_W-1:BYTE_W]};
    assign len_last  = accept & (bcnt_q == 2'd1);
    assign word_last = accept & (bcnt_q == 2'd3);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LEN;
            S_LEN: begin
                if (len_last) begin
                    if (len_next == '0)                  state_d = LAST_NEXT;
                    else if (len_next > LEN_W'(DEPTH))   state_d = S_ERROR;
                    else                                 state_d = S_DATA;
                end
            end
            S_DATA:  if (word_last) state_d = S_WRITE;
            S_WRITE: state_d = ((widx_q + LEN_W'(1)) == len_q) ? LAST_NEXT : S_DATA;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            S_CSUM:  if (accept) state_d = (bus.in_data == csum_q) ? S_DONE : S_ERROR;
`endif
            S_DONE, S_ERROR: if (start) state_d = S_LEN;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so outputs register in step with it
    always_comb begin
        in_ready_d = 1'b0;
        imem_we_d  = 1'b0;
        core_run_d = 1'b0;
        busy_d     = 1'b0;
        err_d      = 1'b0;
        case (state_d)
            S_LEN, S_DATA, S_CSUM: begin
                in_ready_d = 1'b1;
                busy_d     = 1'b1;
            end
            S_WRITE: begin
                imem_we_d = 1'b1;
                busy_d    = 1'b1;
            end
            S_DONE:  core_run_d = 1'b1;
            S_ERROR: err_d      = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.in_ready   <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            core_run       <= 1'b0;
            busy           <= 1'b0;
            err            <= 1'b0;
        end else begin
            bus.in_ready <= in_ready_d;
            bus.imem_we  <= imem_we_d;
            core_run     <= core_run_d;
            busy         <= busy_d;
            err          <= err_d;
            // Address/data hold their last values outside WRITE
            if (state_d == S_WRITE) begin
                bus.imem_addr  <= ADDR_W'(widx_q);
                bus.imem_wdata <= word_next;
            end
        end
    end

    // Length, byte/word counters and word assembly
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q  <= '0;
            widx_q <= '0;
            bcnt_q <= '0;
            word_q <= '0;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            csum_q <= '0;
`endif
        end else if (reload) begin
            len_q  <= '0;
            widx_q <= '0;
            bcnt_q <= '0;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            csum_q <= '0;
`endif
        end else begin
            case (state_q)
                S_LEN: if (accept) begin
                    if (bcnt_q == 2'd0) len_q[BYTE_W-1:0]     <= bus.in_data;
                    else                len_q[LEN_W-1:BYTE_W] <= bus.in_data;
                    bcnt_q <= len_last ? 2'd0 : 2'd1;
                end
                S_DATA: if (accept) begin
                    word_q <= word_next;
                    bcnt_q <= bcnt_q + 2'd1;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                    csum_q <= csum_q ^ bus.in_data;
`endif
                end
                S_WRITE: widx_q <= widx_q + LEN_W'(1);
                default: ;
            endcase
        end
    end
endmodule
